// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge state encoding, data width, slave-index sizing
// and the response record returned to the requester.
package apb_pkg;

    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  error;
    } apb_rsp_t;

    // Width of a slave index; a single slave still needs one bit to hold index 0.
    function automatic int apb_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response handshake plus APB bus signals of the master bridge.
// The master modport is the bridge view; the slave modport is the CPU + peripheral side.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int NSLAVES = 4,
    parameter int ADDR_W  = 8
);

    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [31:0]                   req_addr;
    logic [APB_DATA_W-1:0]         req_wdata;
    logic                          rsp_valid;
    logic [APB_DATA_W-1:0]         rsp_rdata;
    logic                          rsp_error;

    logic [NSLAVES-1:0]            PSEL;
    logic [ADDR_W-1:0]             PADDR;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [APB_DATA_W-1:0]         PWDATA;
    logic [APB_DATA_W*NSLAVES-1:0] PRDATA;
    logic [NSLAVES-1:0]            PREADY;
    logic [NSLAVES-1:0]            PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational slave decode of the address bits above the per-slave window.
// Any nonzero bit beyond the valid index range counts as a decode miss.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int NSLAVES = 4,
    parameter int UPPER_W = 24,
    localparam int IW     = apb_idx_w(NSLAVES)
) (
    input  logic [UPPER_W-1:0] upper_i,
    output logic [NSLAVES-1:0] sel_o,
    output logic [IW-1:0]      idx_o,
    output logic               miss_o
);

    assign miss_o = (upper_i >= UPPER_W'(NSLAVES));
    assign idx_o  = upper_i[IW-1:0];

    // One-hot select, forced empty on a miss.
    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            sel_o[i] = !miss_o && (idx_o == IW'(i));
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: one outstanding CPU request turned into a SETUP/ACCESS transfer,
// with a bounded ACCESS wait and a one-cycle response strobe.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int NSLAVES = 4,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_bridge_if.master bus
);

    localparam int IW      = apb_idx_w(NSLAVES);
    localparam int UPPER_W = 32 - ADDR_W;
    localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    apb_state_e            state_q, state_d;
    logic [NSLAVES-1:0]    psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    apb_rsp_t              rsp_q, rsp_d;

    logic [NSLAVES-1:0]    dec_sel_s;
    logic [IW-1:0]         dec_idx_s;
    logic                  dec_miss_s;
    logic [APB_DATA_W-1:0] prdata_sel_s;
    logic                  pready_sel_s;
    logic                  pslverr_sel_s;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  expired_s;

    apb_addr_decoder #(
        .NSLAVES (NSLAVES),
        .UPPER_W (UPPER_W)
    ) u_dec (
        .upper_i (bus.req_addr[31:ADDR_W]),
        .sel_o   (dec_sel_s),
        .idx_o   (dec_idx_s),
        .miss_o  (dec_miss_s)
    );

    assign prdata_sel_s  = bus.PRDATA[APB_DATA_W*idx_q +: APB_DATA_W];
    assign pready_sel_s  = bus.PREADY[idx_q];
    assign pslverr_sel_s = bus.PSLVERR[idx_q];

    // Counter never exceeds TIMEOUT, so the increment cannot wrap while enabled.
    assign cnt_nxt_s = cnt_q + CNT_W'(1);
    assign expired_s = (TIMEOUT != 0) && (cnt_nxt_s == CNT_W'(TIMEOUT));

    // Next-state and next-output logic; every register holds unless a state moves it.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    pwrite_d = bus.req_write;
                    paddr_d  = bus.req_addr[ADDR_W-1:0];
                    pwdata_d = bus.req_wdata;
                    idx_d    = dec_idx_s;
                    if (dec_miss_s) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_d.error = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        psel_d  = dec_sel_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                // A ready slave wins over a timeout expiring in the same cycle.
                if (pready_sel_s) begin
                    state_d     = ST_RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d.rdata = pwrite_q ? '0 : prdata_sel_s;
                    rsp_d.error = pslverr_sel_s;
                end else if (expired_s) begin
                    state_d     = ST_RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d.error = 1'b1;
                end else begin
                    cnt_d = cnt_nxt_s;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_error = rsp_q.error;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized transfers against a transaction-level model of the bridge
// (decode rule, wait/timeout rule, cycle-accurate latency derived from the wait count).
module tb_apb_master_bridge;

    localparam int NS = 4;
    localparam int AW = 8;
    localparam int TO = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    apb_master_bridge_if #(.NSLAVES(NS), .ADDR_W(AW)) bus ();

    apb_master_bridge #(.NSLAVES(NS), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random bus noise on every slave, with the addressed slave's data/error pinned.
    task automatic drive_slaves(input int idx, input logic [31:0] rd, input logic err, input logic rdy);
        for (int i = 0; i < NS; i++) begin
            bus.PRDATA[32*i +: 32] = $urandom;
            bus.PSLVERR[i]         = 1'($urandom_range(0, 1));
            bus.PREADY[i]          = 1'($urandom_range(0, 1));
        end
        if (idx < NS) begin
            bus.PRDATA[32*idx +: 32] = rd;
            bus.PSLVERR[idx]         = err;
            bus.PREADY[idx]          = rdy;
        end
    endtask

    // One request; waits = ACCESS cycles with PREADY low before it rises (>= TO never rises in time).
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic err_bit, input logic [31:0] rd);
        logic [23:0]   upper;
        logic          miss;
        logic          tmo;
        int            idx;
        int            acc;
        int            total;
        logic [NS-1:0] oh;
        logic          exp_err;
        logic [31:0]   exp_rd;
        logic [NS-1:0] exp_psel;
        logic          rdy;

        upper = addr[31:AW];
        miss  = (upper >= 24'(NS));
        idx   = miss ? NS : int'(upper);
        oh    = '0;
        if (!miss) oh[idx] = 1'b1;
        tmo     = !miss && (waits >= TO);
        acc     = tmo ? TO : waits + 1;
        total   = miss ? 1 : 2 + acc;
        exp_err = miss || tmo || err_bit;
        exp_rd  = (miss || tmo || wr) ? 32'h0 : rd;

        chk("idle_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        drive_slaves(idx, rd, err_bit, 1'($urandom_range(0, 1)));

        for (int c = 1; c <= total + 1; c++) begin
            tick();
            // Request lines are don't-care while busy; drop valid before IDLE is re-entered.
            bus.req_valid = (c <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            if (!miss && c >= 2 && c < total)
                rdy = (c == waits + 2);
            else
                rdy = 1'($urandom_range(0, 1));
            drive_slaves(idx, rd, err_bit, rdy);

            exp_psel = (!miss && c < total) ? oh : '0;
            chk("rsp_valid", bus.rsp_valid, (c == total));
            chk("req_ready", bus.req_ready, (c == total + 1));
            chk("psel", bus.PSEL, exp_psel);
            chk("penable", bus.PENABLE, (!miss && c >= 2 && c < total));
            if (!miss && c < total) begin
                chk("paddr", bus.PADDR, addr[AW-1:0]);
                chk("pwrite", bus.PWRITE, wr);
                chk("pwdata", bus.PWDATA, wd);
            end
            if (c == total) begin
                chk("rsp_rdata", bus.rsp_rdata, exp_rd);
                chk("rsp_error", bus.rsp_error, exp_err);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] r;

        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.PRDATA    = '0;
        bus.PREADY    = '0;
        bus.PSLVERR   = '0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_psel", bus.PSEL, 4'b0000);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_pwrite", bus.PWRITE, 1'b0);
        chk("rst_paddr", bus.PADDR, 8'h00);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_error", bus.rsp_error, 1'b0);
        chk("rst_req_ready", bus.req_ready, 1'b1);

        // Directed cases.
        xfer(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 3, 1'b0, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h0000_0220, 32'h0, 1, 1'b1, 32'h5A5A_1234);
        xfer(1'b0, 32'h0000_0500, 32'h0, 0, 1'b0, 32'h1111_2222);
        xfer(1'b0, 32'h0000_0308, 32'h0, 100, 1'b0, 32'h3333_4444);
        xfer(1'b0, 32'h0000_0308, 32'h0, 3, 1'b0, 32'h7777_8888);
        xfer(1'b1, 32'h0000_0204, 32'hABCD_0001, 4, 1'b1, 32'h9999_0000);

        // Reset in the middle of an ACCESS phase.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0320;
        bus.req_wdata = 32'h0;
        bus.PREADY    = '0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_penable", bus.PENABLE, 1'b1);
        chk("pre_rst_psel", bus.PSEL, 4'b1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_psel", bus.PSEL, 4'b0000);
        chk("mid_rst_penable", bus.PENABLE, 1'b0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_ready", bus.req_ready, 1'b1);
            chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
        end

        // Randomized transfers, including decode misses and timeouts.
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[31:AW] = 24'($urandom_range(0, 5));
            w = $urandom;
            r = $urandom;
            xfer(1'($urandom_range(0, 1)), a, w, $urandom_range(0, 6),
                 1'($urandom_range(0, 1)), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
